spi_regfile: RTL and testbench
==============================

# spi_regfile

Parametrised SPI-target register file: a bank of `NREGS` registers, each `DATA_W` bits, read and written over a 4-wire SPI link in mode 0. It runs entirely in the system clock domain and oversamples the SPI pins through synchronisers. It adds register addressing, burst auto-increment with wrap, atomic word commit, and a parallel write-notify port toward the host logic. It sits between an external SPI master and on-chip control logic, which reads `REG_Q` and reacts to `WR_STB`.

## Interface
- `DATA_W`, 16: register width; legal range 8..32.
- `NREGS`, 4: number of registers; legal range 1..16.
- `RESET_VAL`, 16'hABCD: reset and power-on value of every register, `DATA_W` bits.
- `CLK` input 1: system clock. One clock; all state is on its rising edge.
- `RST_n` input 1: asynchronous, active-low reset.
- `SCLK` input 1: SPI clock, asynchronous to `CLK`, idles low.
- `CS_n` input 1: SPI chip select, active low, asynchronous.
- `SDI` input 1: SPI data from the master.
- `SDO` output 1: SPI data to the master; high when unused.
- `REG_Q` output `NREGS*DATA_W`: all registers; register k is at bits [k*DATA_W +: DATA_W].
- `WR_STB` output 1: one-`CLK` pulse when a PUT word commits.
- `WR_ADDR` output 4: index of the committed register; valid while `WR_STB`=1.

## Operation
- **Input conditioning:** `SCLK`, `CS_n` and `SDI` each pass through a 2-flop synchroniser. Rise and fall events on `SCLK` come from comparing the synchronised value with a third flop. Synchronised `SDI` is used at a rise event.
- **Reset (`RST_n`=0):** state=IDLE, `SDO`=1, `WR_STB`=0, `WR_ADDR`=0, all registers=`RESET_VAL`, bit counter=0.
- **Command byte:** MSB first.
  - [7:4] = opcode: 4'h5 is GET, 4'h4 is PUT.
  - [3:0] = start address.
- **States:**
  - IDLE: synchronised `CS_n`=1. `SDO`=1. Counters clear. Goes to CMD when synchronised `CS_n` falls.
  - CMD: shift `SDI` on each rise event. On the 8th rise, decode the byte:
    - GET with address < `NREGS`: go to GET, load the shift register with the addressed register.
    - PUT with address < `NREGS`: go to PUT, clear the bit counter.
    - Any other byte: go to DONE.
  - GET: on each fall event, `SDO` = shift register MSB and the shift register shifts left. On each rise event the bit counter increments. When it reaches `DATA_W`:
    - the address becomes (addr+1) mod `NREGS`,
    - the shift register reloads with that register (a snapshot),
    - the counter clears.
  - PUT: on each rise event, `SDI` shifts into a shadow word. When `DATA_W` bits have been received:
    - the shadow word is written to the register at the current address, together with a `WR_STB` pulse and `WR_ADDR`=address, in the following `CLK` cycle;
    - the address becomes (addr+1) mod `NREGS`;
    - the counter clears.
  - DONE: `SDO`=1; `SCLK` activity is ignored until `CS_n` goes high.
- **Aborted transfers:** synchronised `CS_n`=1 returns every state to IDLE on the next `CLK`, with `SDO`=1. A partial PUT word is discarded and produces no strobe. A partial GET word has no side effects.
- **Simultaneous events:**
  - A `CS_n` rise in the same `CLK` as an `SCLK` event: the `CS_n` rise wins and the edge is ignored.
  - `RST_n` low overrides everything, including a pending commit.
- **Read atomicity:** GET data is the snapshot taken at load time. Host-side changes during the word are not visible until the next word.
- **Address wrap:** a burst past `NREGS-1` continues at register 0.

## Timing
- **Synchroniser latency:** `SCLK` events are detected 3 `CLK` cycles after the pin edge. `SDO` changes 3–4 `CLK` cycles after the `SCLK` falling edge at the pin.
- **Minimum SPI timing:**
  - `SCLK` high time and low time are each ≥ 4 `CLK` periods.
  - `CS_n` setup before the first `SCLK` rise is ≥ 4 `CLK` periods.
  - `CS_n` high time is ≥ 4 `CLK` periods.
- **`SDO` timing:**
  - The master samples `SDO` on `SCLK` rising edges.
  - The first GET data bit (MSB) appears after the falling edge that follows the 8th command rising edge.
  - `SDO` never changes at a rise event.
- **Commit timing:** `REG_Q` updates in the same `CLK` edge that asserts `WR_STB`, which is 1 `CLK` after the final-bit rise event. `WR_STB` is high for exactly 1 `CLK`.
- **Throughput:** bursts are gapless; there are no dead `SCLK` cycles between words.

## Test plan
All cases use `DATA_W`=16, `NREGS`=4 and `SCLK` = `CLK`/10.
- Reset, then GET command 0x52 with 16 clocks → `SDO` returns 0xABCD MSB first; `SDO`=1 before the first data bit and after `CS_n` rises.
- PUT 0x41 with data 0x1234 → a single `WR_STB` with `WR_ADDR`=1, `REG_Q`[31:16]=0x1234; a following GET 0x51 returns 0x1234.
- Burst PUT 0x43 with 0x1111 then 0x2222 → strobes at `WR_ADDR`=3 then 0; reg3=0x1111, reg0=0x2222. A burst GET 0x53 with 32 clocks returns 0x1111 then 0x2222.
- PUT 0x40 with 9 data bits, then `CS_n` high → no `WR_STB`, reg0 unchanged. The next GET 0x50 works normally.
- Command 0x77, and command 0x44 (address 4 ≥ `NREGS`), each with 16 further clocks → `SDO` stays 1, no `WR_STB`, `REG_Q` unchanged.
- `RST_n` pulsed low mid-GET → `SDO`=1 and all registers=0xABCD immediately. After `RST_n` release and a `CS_n` high/low cycle, GET 0x50 returns 0xABCD.

Source files
------------

// File: rtl/spi_regfile_if.sv
// SPI pin bundle plus host-side register/notify outputs of spi_regfile.
interface spi_regfile_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 4
);
  logic                      SCLK;
  logic                      CS_n;
  logic                      SDI;
  logic                      SDO;
  logic [NREGS*DATA_W-1:0]   REG_Q;
  logic                      WR_STB;
  logic [3:0]                WR_ADDR;

  modport slave (
    input  SCLK, CS_n, SDI,
    output SDO, REG_Q, WR_STB, WR_ADDR
  );

  modport master (
    output SCLK, CS_n, SDI,
    input  SDO, REG_Q, WR_STB, WR_ADDR
  );
endinterface

// File: rtl/spi_regfile.sv
// SPI mode-0 target register file, oversampled in the CLK domain.
// Command byte [7:4]=opcode (5 GET, 4 PUT), [3:0]=start address;
// bursts auto-increment and wrap at NREGS.
module spi_regfile #(
  parameter int unsigned          DATA_W    = 16,
  parameter int unsigned          NREGS     = 4,
  parameter logic [DATA_W-1:0]    RESET_VAL = 16'hABCD
) (
  input  logic         CLK,
  input  logic         RST_n,
  spi_regfile_if.slave bus
);

  localparam int unsigned RW        = NREGS * DATA_W;
  localparam logic [4:0]  LAST_BIT  = 5'(DATA_W - 1);
  localparam logic [3:0]  LAST_ADDR = 4'(NREGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_GET,
    ST_PUT,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_s3_q, sclk_s3_d;
  logic              cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
  logic              sdi_s1_q, sdi_s1_d, sdi_s2_q, sdi_s2_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [6:0]        cmd_q, cmd_d;
  logic [3:0]        addr_q, addr_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              sdo_q, sdo_d;
  logic              commit_q, commit_d;
  logic [3:0]        commit_addr_q, commit_addr_d;
  logic              wr_stb_q, wr_stb_d;
  logic [3:0]        wr_addr_q, wr_addr_d;
  logic [RW-1:0]     regs_q, regs_d;

  logic              rise, fall;
  logic [7:0]        cmd_byte;
  logic              addr_ok;

  assign rise     = sclk_s2_q & ~sclk_s3_q;
  assign fall     = ~sclk_s2_q & sclk_s3_q;
  assign cmd_byte = {cmd_q, sdi_s2_q};
  assign addr_ok  = ({1'b0, cmd_byte[3:0]} < 5'(NREGS));

  assign bus.SDO     = sdo_q;
  assign bus.REG_Q   = regs_q;
  assign bus.WR_STB  = wr_stb_q;
  assign bus.WR_ADDR = wr_addr_q;

  function automatic logic [DATA_W-1:0] reg_sel(input logic [RW-1:0] regs,
                                                input logic [3:0]    a);
    reg_sel = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (a == 4'(k)) reg_sel = regs[k*DATA_W +: DATA_W];
    end
  endfunction

  function automatic logic [3:0] next_addr(input logic [3:0] a);
    next_addr = (a == LAST_ADDR) ? 4'd0 : a + 4'd1;
  endfunction

  // Next-state: synchronisers, transfer FSM and the deferred word commit.
  always_comb begin
    sclk_s1_d     = bus.SCLK;
    sclk_s2_d     = sclk_s1_q;
    sclk_s3_d     = sclk_s2_q;
    cs_s1_d       = bus.CS_n;
    cs_s2_d       = cs_s1_q;
    sdi_s1_d      = bus.SDI;
    sdi_s2_d      = sdi_s1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    sh_d          = sh_q;
    sdo_d         = sdo_q;
    commit_d      = 1'b0;
    commit_addr_d = commit_addr_q;
    wr_stb_d      = 1'b0;
    wr_addr_d     = wr_addr_q;
    regs_d        = regs_q;

    // A completed PUT word lands one cycle after its last bit, even if CS_n
    // has risen meanwhile; the shadow is stable because SCLK is much slower.
    if (commit_q) begin
      wr_stb_d  = 1'b1;
      wr_addr_d = commit_addr_q;
      for (int unsigned k = 0; k < NREGS; k++) begin
        if (commit_addr_q == 4'(k)) regs_d[k*DATA_W +: DATA_W] = sh_q;
      end
    end

    // Deselect has priority over any SCLK event seen in the same cycle.
    if (cs_s2_q) begin
      state_d = ST_IDLE;
      sdo_d   = 1'b1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          sdo_d   = 1'b1;
          cnt_d   = '0;
        end
        ST_CMD: begin
          sdo_d = 1'b1;
          if (rise) begin
            cmd_d = {cmd_q[5:0], sdi_s2_q};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d  = '0;
              addr_d = cmd_byte[3:0];
              if (cmd_byte[7:4] == 4'h5 && addr_ok) begin
                state_d = ST_GET;
                sh_d    = reg_sel(regs_q, cmd_byte[3:0]);
              end else if (cmd_byte[7:4] == 4'h4 && addr_ok) begin
                state_d = ST_PUT;
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_GET: begin
          if (fall) begin
            sdo_d = sh_q[DATA_W-1];
            sh_d  = {sh_q[DATA_W-2:0], 1'b0};
          end else if (rise) begin
            if (cnt_q == LAST_BIT) begin
              cnt_d  = '0;
              addr_d = next_addr(addr_q);
              sh_d   = reg_sel(regs_q, next_addr(addr_q));
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        ST_PUT: begin
          if (rise) begin
            sh_d = {sh_q[DATA_W-2:0], sdi_s2_q};
            if (cnt_q == LAST_BIT) begin
              cnt_d         = '0;
              commit_d      = 1'b1;
              commit_addr_d = addr_q;
              addr_d        = next_addr(addr_q);
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        default: begin
          state_d = ST_DONE;
          sdo_d   = 1'b1;
        end
      endcase
    end
  end

  // State registers; reset also cancels a pending commit.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sclk_s1_q     <= 1'b0;
      sclk_s2_q     <= 1'b0;
      sclk_s3_q     <= 1'b0;
      cs_s1_q       <= 1'b1;
      cs_s2_q       <= 1'b1;
      sdi_s1_q      <= 1'b0;
      sdi_s2_q      <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cmd_q         <= '0;
      addr_q        <= '0;
      sh_q          <= '0;
      sdo_q         <= 1'b1;
      commit_q      <= 1'b0;
      commit_addr_q <= '0;
      wr_stb_q      <= 1'b0;
      wr_addr_q     <= '0;
      regs_q        <= {NREGS{RESET_VAL}};
    end else begin
      sclk_s1_q     <= sclk_s1_d;
      sclk_s2_q     <= sclk_s2_d;
      sclk_s3_q     <= sclk_s3_d;
      cs_s1_q       <= cs_s1_d;
      cs_s2_q       <= cs_s2_d;
      sdi_s1_q      <= sdi_s1_d;
      sdi_s2_q      <= sdi_s2_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      sh_q          <= sh_d;
      sdo_q         <= sdo_d;
      commit_q      <= commit_d;
      commit_addr_q <= commit_addr_d;
      wr_stb_q      <= wr_stb_d;
      wr_addr_q     <= wr_addr_d;
      regs_q        <= regs_d;
    end
  end

endmodule

// File: tb/tb_spi_regfile.sv
// Self-checking bench for spi_regfile (DATA_W=16, NREGS=4, SCLK=CLK/10).
module tb_spi_regfile;

  logic CLK = 1'b0;
  logic RST_n;

  always #5 CLK = ~CLK;

  spi_regfile_if #(.DATA_W(16), .NREGS(4)) bus ();

  spi_regfile #(
    .DATA_W   (16),
    .NREGS    (4),
    .RESET_VAL(16'hABCD)
  ) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference register contents.
  logic [15:0] mdl[4];
  // Strobes seen by the monitor, and strobes the model predicts.
  int          obs_addr[$];
  logic [15:0] obs_data[$];
  int          exp_addr[$];
  logic [15:0] exp_data[$];

  always @(negedge CLK) begin
    if (RST_n === 1'b1 && bus.WR_STB === 1'b1) begin
      obs_addr.push_back(int'(bus.WR_ADDR));
      obs_data.push_back(bus.REG_Q[int'(bus.WR_ADDR)*16 +: 16]);
    end
  end

  function automatic logic [63:0] mdl_vec();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  function automatic void model_put(input int start, input logic [15:0] words[$]);
    int a = start;
    foreach (words[i]) begin
      mdl[a] = words[i];
      exp_addr.push_back(a);
      exp_data.push_back(words[i]);
      a = (a + 1) % 4;
    end
  endfunction

  task automatic clear_strobes();
    obs_addr.delete(); obs_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic spi_bit(input logic v, output logic so);
    bus.SDI = v;
    repeat (5) @(negedge CLK);
    bus.SCLK = 1'b1;
    so = bus.SDO;
    repeat (5) @(negedge CLK);
    bus.SCLK = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input int nbits, input logic [127:0] din,
                          output logic [7:0] cmd_so, output logic [127:0] dout);
    logic b;
    dout = '0;
    bus.CS_n = 1'b0;
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      spi_bit(cmd[7-i], b);
      cmd_so[7-i] = b;
    end
    for (int i = 0; i < nbits; i++) begin
      spi_bit(din[nbits-1-i], b);
      dout[nbits-1-i] = b;
    end
    repeat (5) @(negedge CLK);
    bus.CS_n = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    bus.SCLK = 1'b0; bus.CS_n = 1'b1; bus.SDI = 1'b0;
    repeat (4) @(negedge CLK);
    foreach (mdl[i]) mdl[i] = 16'hABCD;
    checks++; if (bus.SDO !== 1'b1) begin errors++; $display("FAIL reset_sdo got %b expected 1", bus.SDO); end
    checks++; if (bus.WR_STB !== 1'b0) begin errors++; $display("FAIL reset_stb got %b expected 0", bus.WR_STB); end
    checks++; if (bus.WR_ADDR !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d expected 0", bus.WR_ADDR); end
    checks++; if (bus.REG_Q !== 64'hABCD_ABCD_ABCD_ABCD) begin errors++; $display("FAIL reset_regs got %h expected abcdabcdabcdabcd", bus.REG_Q); end
    RST_n = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_get_reset();
    logic [7:0] cso; logic [127:0] dout;
    clear_strobes();
    spi_xfer(8'h52, 16, '0, cso, dout);
    checks++; if (cso !== 8'hFF) begin errors++; $display("FAIL get_cmd_sdo got %h expected ff", cso); end
    checks++; if (dout[15:0] !== 16'hABCD) begin errors++; $display("FAIL get_reset_data got %h expected abcd", dout[15:0]); end
    checks++; if (bus.SDO !== 1'b1) begin errors++; $display("FAIL get_sdo_idle got %b expected 1", bus.SDO); end
    checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL get_no_stb got %0d expected 0", obs_addr.size()); end
  endtask

  task automatic test_put_single();
    logic [7:0] cso; logic [127:0] dout; logic [15:0] w[$];
    clear_strobes();
    w = '{16'h1234};
    model_put(1, w);
    spi_xfer(8'h41, 16, 128'h1234, cso, dout);
    checks++; if (obs_addr.size() != 1) begin errors++; $display("FAIL put1_count got %0d expected 1", obs_addr.size()); end
    else begin
      checks++; if (obs_addr[0] != 1) begin errors++; $display("FAIL put1_addr got %0d expected 1", obs_addr[0]); end
      checks++; if (obs_data[0] !== 16'h1234) begin errors++; $display("FAIL put1_data got %h expected 1234", obs_data[0]); end
    end
    checks++; if (bus.REG_Q[31:16] !== 16'h1234) begin errors++; $display("FAIL put1_regq got %h expected 1234", bus.REG_Q[31:16]); end
    spi_xfer(8'h51, 16, '0, cso, dout);
    checks++; if (dout[15:0] !== 16'h1234) begin errors++; $display("FAIL put1_readback got %h expected 1234", dout[15:0]); end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] cso; logic [127:0] dout; logic [15:0] w[$];
    clear_strobes();
    w = '{16'h1111, 16'h2222};
    model_put(3, w);
    spi_xfer(8'h43, 32, 128'h1111_2222, cso, dout);
    checks++; if (obs_addr.size() != 2) begin errors++; $display("FAIL burst_count got %0d expected 2", obs_addr.size()); end
    else begin
      checks++; if (obs_addr[0] != 3 || obs_addr[1] != 0) begin errors++; $display("FAIL burst_addr got %0d,%0d expected 3,0", obs_addr[0], obs_addr[1]); end
    end
    checks++; if (bus.REG_Q !== mdl_vec()) begin errors++; $display("FAIL burst_regq got %h expected %h", bus.REG_Q, mdl_vec()); end
    spi_xfer(8'h53, 32, '0, cso, dout);
    checks++; if (dout[31:0] !== 32'h1111_2222) begin errors++; $display("FAIL burst_get got %h expected 11112222", dout[31:0]); end
    // After the burst the reloaded word (reg1=0x1234) drives SDO low until deselect.
    checks++; if (bus.SDO !== 1'b1) begin errors++; $display("FAIL burst_sdo_idle got %b expected 1", bus.SDO); end
  endtask

  task automatic test_abort_put();
    logic [7:0] cso; logic [127:0] dout;
    clear_strobes();
    spi_xfer(8'h40, 9, 128'h1AB, cso, dout);
    checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL abort_stb got %0d expected 0", obs_addr.size()); end
    checks++; if (bus.REG_Q !== mdl_vec()) begin errors++; $display("FAIL abort_regq got %h expected %h", bus.REG_Q, mdl_vec()); end
    spi_xfer(8'h50, 16, '0, cso, dout);
    checks++; if (dout[15:0] !== mdl[0]) begin errors++; $display("FAIL abort_get got %h expected %h", dout[15:0], mdl[0]); end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] cso; logic [127:0] dout;
    logic [7:0] cmds[2];
    cmds[0] = 8'h77; cmds[1] = 8'h44;
    foreach (cmds[i]) begin
      clear_strobes();
      spi_xfer(cmds[i], 16, 128'h5A5A, cso, dout);
      checks++; if (cso !== 8'hFF || dout[15:0] !== 16'hFFFF) begin errors++; $display("FAIL bad_sdo cmd %h got %h/%h expected ff/ffff", cmds[i], cso, dout[15:0]); end
      checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL bad_stb cmd %h got %0d expected 0", cmds[i], obs_addr.size()); end
      checks++; if (bus.REG_Q !== mdl_vec()) begin errors++; $display("FAIL bad_regq cmd %h got %h expected %h", cmds[i], bus.REG_Q, mdl_vec()); end
    end
  endtask

  task automatic test_random();
    logic [7:0] cso; logic [127:0] dout, din; logic [15:0] w[$];
    int a, n, ga, gn;
    for (int it = 0; it < 6; it++) begin
      clear_strobes();
      a = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 3));
      w.delete(); din = '0;
      for (int k = 0; k < n; k++) begin
        w.push_back(16'($urandom));
        din = (din << 16) | 128'(w[k]);
      end
      model_put(a, w);
      spi_xfer(8'h40 | 8'(a), 16*n, din, cso, dout);
      checks++; if (obs_addr.size() != exp_addr.size()) begin errors++; $display("FAIL rnd_stb_count it%0d got %0d expected %0d", it, obs_addr.size(), exp_addr.size()); end
      else begin
        foreach (exp_addr[k]) begin
          checks++;
          if (obs_addr[k] != exp_addr[k] || obs_data[k] !== exp_data[k]) begin
            errors++; $display("FAIL rnd_stb it%0d #%0d got %0d:%h expected %0d:%h", it, k, obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
          end
        end
      end
      checks++; if (bus.REG_Q !== mdl_vec()) begin errors++; $display("FAIL rnd_regq it%0d got %h expected %h", it, bus.REG_Q, mdl_vec()); end
      ga = int'($urandom_range(0, 3));
      gn = int'($urandom_range(1, 4));
      spi_xfer(8'h50 | 8'(ga), 16*gn, '0, cso, dout);
      for (int k = 0; k < gn; k++) begin
        checks++;
        if (dout[16*(gn-1-k) +: 16] !== mdl[(ga+k)%4]) begin
          errors++; $display("FAIL rnd_get it%0d word%0d got %h expected %h", it, k, dout[16*(gn-1-k) +: 16], mdl[(ga+k)%4]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_get();
    logic [7:0] cso; logic [127:0] dout; logic b;
    logic [7:0] cmd;
    cmd = 8'h50;
    bus.CS_n = 1'b0;
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 8; i++) spi_bit(cmd[7-i], b);
    for (int i = 0; i < 5; i++) spi_bit(1'b0, b);
    RST_n = 1'b0;
    #1;
    checks++; if (bus.SDO !== 1'b1) begin errors++; $display("FAIL rstmid_sdo got %b expected 1", bus.SDO); end
    checks++; if (bus.REG_Q !== 64'hABCD_ABCD_ABCD_ABCD) begin errors++; $display("FAIL rstmid_regs got %h expected abcdabcdabcdabcd", bus.REG_Q); end
    foreach (mdl[i]) mdl[i] = 16'hABCD;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    bus.CS_n = 1'b1;
    repeat (6) @(negedge CLK);
    spi_xfer(8'h50, 16, '0, cso, dout);
    checks++; if (dout[15:0] !== 16'hABCD) begin errors++; $display("FAIL rstmid_get got %h expected abcd", dout[15:0]); end
  endtask

  initial begin
    test_reset();
    test_get_reset();
    test_put_single();
    test_burst_wrap();
    test_abort_put();
    test_bad_cmd();
    test_random();
    test_reset_mid_get();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
